channel_in_acc_ctrl: RTL and testbench
======================================

CHANNEL_IN_ACC_CTRL -- requirements
Module: channel_in_acc_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- LANES, 8, parallel picture lanes in the tree result.
- SUM_W, 32, signed width per lane.
- TREE_LAT, 5, adder-tree depth in cycles.
- FIFO_DEPTH, 4, result FIFO entries (power of two).

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all logic rising-edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle job launch.
- group_num, in, 8, 32-channel groups per output pixel; latched on start.
- pix_num, in, 16, output pixels per job; latched on start.
- in_valid, in, 1, upstream presents one 32-channel beat to the tree.
- in_ready, out, 1, beat accepted into the tree when in_valid&in_ready.
- tree_sum, in, LANES*SUM_W, adder-tree output; lane k at bits [k*SUM_W +: SUM_W].
- out_valid, out, 1, FIFO head holds a finished pixel.
- out_ready, in, 1, downstream accepts; pops on out_valid&out_ready.
- out_data, out, LANES*SUM_W, finished pixel sums.
- busy, out, 1, high in RUN or DRAIN.
- done, out, 1, one-cycle job-complete pulse.

Function
REQ-003 FSM states: IDLE, RUN, DRAIN.
REQ-004 IDLE: start with both group_num and pix_num nonzero latches the config, clears counters, and moves to RUN.
REQ-005 IDLE: start with either value zero pulses done on the next cycle and stays in IDLE.
REQ-006 start outside IDLE is ignored.
REQ-007 RUN: in_ready = credit>0, where credit = FIFO_DEPTH − (results in flight + FIFO occupancy).
- credit is decremented on accepting a last-group beat.
- credit is incremented on an output pop.
- A simultaneous accept and pop leaves credit unchanged.
REQ-008 In IDLE and DRAIN, in_ready is 0.
REQ-009 Each accepted beat pushes a tag {valid, first, last} into a TREE_LAT-deep shift register.
- first = (grp_cnt==0).
- last = (grp_cnt==group_num−1).
REQ-010 grp_cnt wraps to 0 after group_num−1, then pix_cnt increments.
- Accepting the last group of pixel pix_num−1 moves the FSM to DRAIN.
REQ-011 When the tag leaving the shift register is valid:
- acc_next = first ? tree_sum : acc + tree_sum, per lane, signed.
- acc loads acc_next.
- If last is set, acc_next is also written to the FIFO in the same edge.
REQ-012 Latency: a beat accepted in cycle t reaches the accumulator at the edge ending cycle t+TREE_LAT.
- With group_num=1, out_valid first rises in cycle t+TREE_LAT+1.
REQ-013 The FIFO never overflows; a write when full is a design error and is flagged by a bench assertion.
REQ-014 DRAIN: when the tag pipeline and FIFO are both empty, pulse done for one cycle and return to IDLE.
- busy drops in the same cycle done is high.
REQ-015 out_data is the FIFO head and holds stable while out_valid=1 and out_ready=0.
REQ-016 FIFO read and write pointers wrap modulo FIFO_DEPTH; simultaneous read and write on a full or empty FIFO keeps occupancy correct.

Reset
REQ-017 rst_n low asynchronously forces:
- state=IDLE;
- tags, counters, acc, FIFO pointers=0;
- credit=FIFO_DEPTH;
- in_ready=0, out_valid=0, busy=0, done=0, out_data=0.
REQ-018 Reset mid-job discards all in-flight and buffered results; no done is emitted.
REQ-019 Reset is released synchronously to clk by the system; the block needs no internal synchronizer.

Configuration
REQ-020 Macro ACC_SAT_EN:
- Defined: each per-lane add in REQ-011 saturates to [−2^(SUM_W−1), 2^(SUM_W−1)−1].
- Undefined: the add wraps modulo 2^SUM_W.

Verification
REQ-021 group_num=1, pix_num=3, lane sums 1,2,3, out_ready=1 → outputs 1,2,3 in order; first out_valid TREE_LAT+1 cycles after the first accept; done once.
REQ-022 group_num=4, pix_num=2, every lane sum 10 per beat → two outputs of 40 per lane; no output before the 4th beat plus TREE_LAT+1.
REQ-023 group_num=1, pix_num=8, out_ready=0 → in_ready drops after 4 accepts, no FIFO overflow; release out_ready → all 8 results arrive, then done.
REQ-024 Lane sums 0x7FFFFFF0 and 0x20 with group_num=2 → 0x7FFFFFFF with ACC_SAT_EN, 0x80000010 without it.
REQ-025 rst_n asserted low with 3 tags in flight → all outputs 0 immediately; next job with group_num=1, pix_num=1 produces exactly one correct result.
REQ-026 start with pix_num=0 → done on the next cycle, busy stays 0; start pulsed during RUN → ignored, counts unchanged.

Source files
------------

// File: rtl/channel_in_acc_ctrl.sv
// Input-channel accumulation controller: tags adder-tree beats, sums groups per pixel, buffers results in a credit-guarded FIFO.
// Optional macro ACC_SAT_EN makes the per-lane accumulate saturate instead of wrapping.
module channel_in_acc_ctrl #(
    parameter int LANES      = 8,
    parameter int SUM_W      = 32,
    parameter int TREE_LAT   = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [7:0]             group_num,
    input  logic [15:0]            pix_num,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*SUM_W-1:0] tree_sum,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*SUM_W-1:0] out_data,
    output logic                   busy,
    output logic                   done
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                   state, state_next;
    logic                     done_next;
    logic [7:0]               cfg_group, grp_cnt;
    logic [15:0]              cfg_pix, pix_cnt;
    logic [CW-1:0]            credit, fifo_cnt;
    logic [TREE_LAT-1:0]      tag_v, tag_f, tag_l;
    logic [LANES*SUM_W-1:0]   acc, acc_next;
    logic [LANES*SUM_W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic                     accept, beat_last, final_beat, pop, fifo_we, cfg_ok;
    logic [SUM_W-1:0]         lane_a, lane_b, lane_sum;
`ifdef ACC_SAT_EN
    logic [SUM_W:0]           lane_wide;
`endif

    assign cfg_ok     = (group_num != 8'd0) && (pix_num != 16'd0);
    assign in_ready   = (state == RUN) && (credit != '0);
    assign accept     = in_valid && in_ready;
    assign beat_last  = (grp_cnt == cfg_group - 8'd1);
    assign final_beat = accept && beat_last && (pix_cnt == cfg_pix - 16'd1);
    assign out_valid  = (fifo_cnt != '0);
    assign pop        = out_valid && out_ready;
    assign fifo_we    = tag_v[TREE_LAT-1] && tag_l[TREE_LAT-1];
    assign out_data   = out_valid ? mem[rd_ptr] : '0;
    assign busy       = (state != IDLE);

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) state_next = RUN;
                    else        done_next  = 1'b1;
                end
            end
            RUN: begin
                if (final_beat) state_next = DRAIN;
            end
            DRAIN: begin
                if ((tag_v == '0) && (fifo_cnt == '0)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_group <= '0;
            cfg_pix   <= '0;
            grp_cnt   <= '0;
            pix_cnt   <= '0;
        end else if ((state == IDLE) && start && cfg_ok) begin
            cfg_group <= group_num;
            cfg_pix   <= pix_num;
            grp_cnt   <= '0;
            pix_cnt   <= '0;
        end else if (accept) begin
            if (beat_last) begin
                grp_cnt <= '0;
                pix_cnt <= pix_cnt + 16'd1;
            end else begin
                grp_cnt <= grp_cnt + 8'd1;
            end
        end
    end

    // Credit reserves a FIFO slot when a pixel's last beat enters the tree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit <= CW'(FIFO_DEPTH);
        end else begin
            case ({accept && beat_last, pop})
                2'b10:   credit <= credit - CW'(1);
                2'b01:   credit <= credit + CW'(1);
                default: credit <= credit;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            tag_f <= '0;
            tag_l <= '0;
        end else begin
            tag_v[0] <= accept;
            tag_f[0] <= accept && (grp_cnt == 8'd0);
            tag_l[0] <= accept && beat_last;
            for (int i = 1; i < TREE_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_f[i] <= tag_f[i-1];
                tag_l[i] <= tag_l[i-1];
            end
        end
    end

    always_comb begin
        acc_next = '0;
        lane_a   = '0;
        lane_b   = '0;
        lane_sum = '0;
`ifdef ACC_SAT_EN
        lane_wide = '0;
`endif
        for (int k = 0; k < LANES; k++) begin
            lane_a = acc[k*SUM_W +: SUM_W];
            lane_b = tree_sum[k*SUM_W +: SUM_W];
`ifdef ACC_SAT_EN
            lane_wide = {lane_a[SUM_W-1], lane_a} + {lane_b[SUM_W-1], lane_b};
            lane_sum  = lane_wide[SUM_W-1:0];
            // Sign bits disagree only when the signed add left the representable range.
            if (lane_wide[SUM_W] != lane_wide[SUM_W-1])
                lane_sum = lane_wide[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
`else
            lane_sum = lane_a + lane_b;
`endif
            acc_next[k*SUM_W +: SUM_W] = tag_f[TREE_LAT-1] ? lane_b : lane_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 acc <= '0;
        else if (tag_v[TREE_LAT-1]) acc <= acc_next;
    end

    always_ff @(posedge clk) begin
        if (fifo_we) mem[wr_ptr] <= acc_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_we) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({fifo_we, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_channel_in_acc_ctrl.sv
// Scoreboard bench for channel_in_acc_ctrl: models the adder-tree delay and the per-pixel lane sums.
module tb_channel_in_acc_ctrl;

    localparam int LANES      = 8;
    localparam int SUM_W      = 32;
    localparam int TREE_LAT   = 5;
    localparam int FIFO_DEPTH = 4;
    localparam int W          = LANES * SUM_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [7:0]    group_num;
    logic [15:0]   pix_num;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  tree_sum;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          busy;
    logic          done;

    logic [W-1:0]  beat_data = '0;
    logic [W-1:0]  pipe [TREE_LAT];
    logic [W-1:0]  sb [$];
    logic [W-1:0]  last_out = '0;
    logic          acc_flag = 1'b0;
    int            checks = 0;
    int            fails = 0;
    int            cyc = 0;
    int            accept_cnt = 0;
    int            done_cnt = 0;
    int            first_out_cyc = -1;
    int            first_last_acc_cyc = -1;

    channel_in_acc_ctrl #(
        .LANES(LANES), .SUM_W(SUM_W), .TREE_LAT(TREE_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .group_num(group_num), .pix_num(pix_num),
        .in_valid(in_valid), .in_ready(in_ready), .tree_sum(tree_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time %0t reached, simulation limit 200000", $time);
        $fatal(1, "[TB] watchdog");
    end

    // Upstream adder tree: an accepted beat appears on tree_sum TREE_LAT edges later.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        pipe[0] <= acc_flag ? beat_data : '0;
        for (int i = 1; i < TREE_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign tree_sum = pipe[TREE_LAT-1];

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        acc_flag = in_valid && in_ready;
        if (acc_flag) accept_cnt++;
        if (done === 1'b1) done_cnt++;
        if (out_valid === 1'b1 && first_out_cyc < 0) first_out_cyc = cyc;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            last_out = out_data;
            if (sb.size() == 0) checkOutput("unexpected_out", 1, 0);
            else                checkOutput("out_data", out_data, sb.pop_front());
        end
        if (rst_n === 1'b1 && dut.fifo_we && dut.fifo_cnt == FIFO_DEPTH)
            checkOutput("fifo_overflow", 1, 0);
    end

    function automatic logic [SUM_W-1:0] modelAdd(input logic [SUM_W-1:0] a, input logic [SUM_W-1:0] b);
        logic signed [SUM_W:0] s;
        s = $signed({a[SUM_W-1], a}) + $signed({b[SUM_W-1], b});
`ifdef ACC_SAT_EN
        if (s > $signed({2'b00, {(SUM_W-1){1'b1}}})) return {1'b0, {(SUM_W-1){1'b1}}};
        if (s < $signed({2'b11, {(SUM_W-1){1'b0}}})) return {1'b1, {(SUM_W-1){1'b0}}};
`endif
        return s[SUM_W-1:0];
    endfunction

    function automatic logic [SUM_W-1:0] laneVal(input int mode, input int p, input int g, input int k);
        case (mode)
            0:       return SUM_W'(p + 1);
            1:       return SUM_W'(10);
            2:       return (g == 0) ? 32'h7FFF_FFF0 : 32'h0000_0020;
            default: return SUM_W'($urandom) + SUM_W'(k);
        endcase
    endfunction

    task automatic startJob(input int g, input int p);
        @(posedge clk) #1;
        start = 1'b1;
        group_num = 8'(g);
        pix_num = 16'(p);
        first_out_cyc = -1;
        first_last_acc_cyc = -1;
        @(posedge clk) #1;
        start = 1'b0;
    endtask

    // Drives up to max_beats beats; the expected pixel is queued when its last beat is accepted.
    task automatic applyStimulus(input int groups, input int pixels, input int mode, input int max_beats);
        logic [SUM_W-1:0] m [LANES];
        logic [W-1:0]     exp;
        int               beats = 0;
        int               t;
        for (int p = 0; p < pixels; p++) begin
            for (int g = 0; g < groups; g++) begin
                if (beats == max_beats) begin
                    in_valid = 1'b0;
                    return;
                end
                for (int k = 0; k < LANES; k++) begin
                    beat_data[k*SUM_W +: SUM_W] = laneVal(mode, p, g, k);
                    m[k] = (g == 0) ? beat_data[k*SUM_W +: SUM_W]
                                    : modelAdd(m[k], beat_data[k*SUM_W +: SUM_W]);
                end
                in_valid = 1'b1;
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (in_ready !== 1'b1 && t < 300);
                if (in_ready !== 1'b1) begin
                    checkOutput("accept_timeout", 0, 1);
                    in_valid = 1'b0;
                    return;
                end
                if (g == groups - 1) begin
                    if (first_last_acc_cyc < 0) first_last_acc_cyc = cyc;
                    for (int k = 0; k < LANES; k++) exp[k*SUM_W +: SUM_W] = m[k];
                    sb.push_back(exp);
                end
                @(posedge clk) #1;
                beats++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int t = 0;
        while ((busy !== 1'b0 || out_valid !== 1'b0 || sb.size() != 0) && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (t >= budget) checkOutput("idle_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_in_ready"}, in_ready, 0);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_out_data"}, out_data, 0);
    endtask

    initial begin
        int d0, a0;
        logic [W-1:0] hold;
        for (int i = 0; i < TREE_LAT; i++) pipe[i] = '0;
        rst_n = 1'b0; start = 1'b0; group_num = '0; pix_num = '0;
        in_valid = 1'b0; out_ready = 1'b0;
        #12;
        checkResetOutputs("reset");
        @(posedge clk) #1 rst_n = 1'b1;

        // Single-group pixels stream straight through.
        out_ready = 1'b1;
        d0 = done_cnt;
        startJob(1, 3);
        applyStimulus(1, 3, 0, 100);
        waitIdle(200);
        checkOutput("t1_latency", first_out_cyc - first_last_acc_cyc, TREE_LAT + 1);
        checkOutput("t1_done", done_cnt - d0, 1);
        checkOutput("t1_lane7", last_out[7*SUM_W +: SUM_W], 3);

        d0 = done_cnt;
        startJob(4, 2);
        applyStimulus(4, 2, 1, 100);
        waitIdle(200);
        checkOutput("t2_latency", first_out_cyc - first_last_acc_cyc, TREE_LAT + 1);
        checkOutput("t2_lane0", last_out[SUM_W-1:0], 40);
        checkOutput("t2_done", done_cnt - d0, 1);

        // Downstream stalled: credit must stop the tree after FIFO_DEPTH pixels.
        out_ready = 1'b0;
        d0 = done_cnt;
        a0 = accept_cnt;
        startJob(1, 8);
        fork
            applyStimulus(1, 8, 0, 100);
            begin
                repeat (20) @(negedge clk);
                checkOutput("t3_accepts", accept_cnt - a0, FIFO_DEPTH);
                checkOutput("t3_in_ready", in_ready, 0);
                checkOutput("t3_out_valid", out_valid, 1);
                checkOutput("t3_head", out_data, sb[0]);
                hold = out_data;
                repeat (3) @(negedge clk);
                checkOutput("t3_hold", out_data, hold);
                @(posedge clk) #1 out_ready = 1'b1;
            end
        join
        waitIdle(300);
        checkOutput("t3_total", accept_cnt - a0, 8);
        checkOutput("t3_done", done_cnt - d0, 1);

        startJob(2, 1);
        applyStimulus(2, 1, 2, 100);
        waitIdle(200);
`ifdef ACC_SAT_EN
        checkOutput("t4_sat", last_out[SUM_W-1:0], 32'h7FFF_FFFF);
`else
        checkOutput("t4_wrap", last_out[SUM_W-1:0], 32'h8000_0010);
`endif

        d0 = done_cnt;
        startJob(1, 0);
        @(negedge clk);
        checkOutput("t5_done", done, 1);
        checkOutput("t5_busy", busy, 0);
        @(negedge clk);
        checkOutput("t5_done_clr", done, 0);
        checkOutput("t5_done_cnt", done_cnt - d0, 1);

        // A start pulse mid-job must not disturb the running configuration.
        d0 = done_cnt;
        a0 = accept_cnt;
        startJob(2, 2);
        fork
            applyStimulus(2, 2, 3, 100);
            begin
                repeat (2) @(posedge clk);
                #1;
                start = 1'b1; group_num = 8'd1; pix_num = 16'd1;
                @(posedge clk) #1 start = 1'b0;
                @(negedge clk);
                checkOutput("t6_busy", busy, 1);
            end
        join
        waitIdle(200);
        checkOutput("t6_accepts", accept_cnt - a0, 4);
        checkOutput("t6_done", done_cnt - d0, 1);

        // Reset with three beats inside the tree.
        d0 = done_cnt;
        startJob(1, 5);
        applyStimulus(1, 5, 0, 3);
        rst_n = 1'b0;
        sb.delete();
        #1;
        checkResetOutputs("midreset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("t7_no_done", done_cnt - d0, 0);
        checkOutput("t7_no_out", out_valid, 0);
        d0 = done_cnt;
        startJob(1, 1);
        applyStimulus(1, 1, 3, 100);
        waitIdle(200);
        checkOutput("t7_latency", first_out_cyc - first_last_acc_cyc, TREE_LAT + 1);
        checkOutput("t7_done", done_cnt - d0, 1);

        checkOutput("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
